// File: rtl/id_ex_pipe_pkg.sv
// Shared constants for the id->ex pipeline register: bubble encoding and
// flush-window counter sizing.
package id_ex_pipe_pkg;

  localparam logic [31:0] INST_NOP  = 32'h00000013;
  localparam logic [31:0] ZERO_WORD = 32'h0;
  localparam logic [4:0]  ZERO_REG  = 5'b0;

  localparam int FLUSH_CNT_W = 3;
  typedef logic [FLUSH_CNT_W-1:0] flush_cnt_t;

  // The window is counted down from cycles-1 because the flush edge itself
  // already inserts the first bubble.
  function automatic flush_cnt_t flush_reload(input int cycles);
    return flush_cnt_t'(cycles - 1);
  endfunction

endpackage

// File: rtl/id_ex_pipe_if.sv
// Bundle between id/ctrl (master) and the id->ex pipeline register (slave).
interface id_ex_if #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
);
  logic [DATA_W-1:0] inst_i;
  logic [DATA_W-1:0] inst_addr_i;
  logic [DATA_W-1:0] op1_i;
  logic [DATA_W-1:0] op2_i;
  logic              reg_wen_i;
  logic [RD_W-1:0]   rd_addr_i;
  logic              valid_i;
  logic              hold_i;
  logic              flush_i;

  logic [DATA_W-1:0] inst_o;
  logic [DATA_W-1:0] inst_addr_o;
  logic [DATA_W-1:0] op1_o;
  logic [DATA_W-1:0] op2_o;
  logic              reg_wen_o;
  logic [RD_W-1:0]   rd_addr_o;
  logic              valid_o;
  logic              flushing_o;
  logic [31:0]       retired_cnt_o;

  modport master (
    output inst_i, inst_addr_i, op1_i, op2_i, reg_wen_i, rd_addr_i, valid_i,
           hold_i, flush_i,
    input  inst_o, inst_addr_o, op1_o, op2_o, reg_wen_o, rd_addr_o, valid_o,
           flushing_o, retired_cnt_o
  );

  modport slave (
    input  inst_i, inst_addr_i, op1_i, op2_i, reg_wen_i, rd_addr_i, valid_i,
           hold_i, flush_i,
    output inst_o, inst_addr_o, op1_o, op2_o, reg_wen_o, rd_addr_o, valid_o,
           flushing_o, retired_cnt_o
  );
endinterface

// File: rtl/id_ex_pipe_gen_pipe_dff.sv
// One pipeline field: reset/clear load the default, hold keeps the value,
// otherwise capture d. Clear wins over hold.
module gen_pipe_dff #(
  parameter int           W       = 32,
  parameter logic [W-1:0] DEFAULT = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clear)
      q <= DEFAULT;
    else if (!hold)
      q <= d;
  end

endmodule

// File: rtl/id_ex_pipe.sv
// id->ex pipeline register with stall/flush control, a flush-window counter
// that bubbles wrong-path slots, and a retired-slot counter.
module id_ex_pipe
  import id_ex_pipe_pkg::*;
#(
  parameter int                DATA_W       = 32,
  parameter int                RD_W         = 5,
  parameter int                FLUSH_CYCLES = 1,
  parameter logic [DATA_W-1:0] NOP_INST     = DATA_W'(INST_NOP)
) (
  input  logic    clk,
  input  logic    rst,
  id_ex_if.slave  bus
);

  localparam flush_cnt_t FLUSH_RELOAD = flush_reload(FLUSH_CYCLES);

  flush_cnt_t  flush_cnt;
  logic        flushing;
  logic        clear_slot;
  logic        retire;
  logic [31:0] retired_cnt;

  assign flushing = (flush_cnt != '0);

  // A bubble goes in on a flush, during the window, or when an unstalled
  // load finds no real instruction in id.
  assign clear_slot = bus.flush_i | flushing | (~bus.hold_i & ~bus.valid_i);

  // The jump sitting in ex is consumed on the flush edge even if ctrl stalls.
  assign retire = bus.valid_o & (~bus.hold_i | bus.flush_i);

  // ---- id -> ex register stage ----
  gen_pipe_dff #(.W(DATA_W), .DEFAULT(NOP_INST)) u_inst (
    .clk(clk), .rst(rst), .hold(bus.hold_i), .clear(clear_slot),
    .d(bus.inst_i), .q(bus.inst_o)
  );

  gen_pipe_dff #(.W(DATA_W), .DEFAULT(DATA_W'(ZERO_WORD))) u_inst_addr (
    .clk(clk), .rst(rst), .hold(bus.hold_i), .clear(clear_slot),
    .d(bus.inst_addr_i), .q(bus.inst_addr_o)
  );

  gen_pipe_dff #(.W(DATA_W), .DEFAULT(DATA_W'(ZERO_WORD))) u_op1 (
    .clk(clk), .rst(rst), .hold(bus.hold_i), .clear(clear_slot),
    .d(bus.op1_i), .q(bus.op1_o)
  );

  gen_pipe_dff #(.W(DATA_W), .DEFAULT(DATA_W'(ZERO_WORD))) u_op2 (
    .clk(clk), .rst(rst), .hold(bus.hold_i), .clear(clear_slot),
    .d(bus.op2_i), .q(bus.op2_o)
  );

  gen_pipe_dff #(.W(1), .DEFAULT(1'b0)) u_reg_wen (
    .clk(clk), .rst(rst), .hold(bus.hold_i), .clear(clear_slot),
    .d(bus.reg_wen_i), .q(bus.reg_wen_o)
  );

  gen_pipe_dff #(.W(RD_W), .DEFAULT(RD_W'(ZERO_REG))) u_rd_addr (
    .clk(clk), .rst(rst), .hold(bus.hold_i), .clear(clear_slot),
    .d(bus.rd_addr_i), .q(bus.rd_addr_o)
  );

  gen_pipe_dff #(.W(1), .DEFAULT(1'b0)) u_valid (
    .clk(clk), .rst(rst), .hold(bus.hold_i), .clear(clear_slot),
    .d(bus.valid_i), .q(bus.valid_o)
  );

  // Hold never freezes the window, so a flush always drains completely.
  always_ff @(posedge clk) begin
    if (rst)
      flush_cnt <= '0;
    else if (bus.flush_i)
      flush_cnt <= FLUSH_RELOAD;
    else if (flushing)
      flush_cnt <= flush_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      retired_cnt <= '0;
    else if (retire)
      retired_cnt <= retired_cnt + 32'd1;
  end

  assign bus.flushing_o    = flushing;
  assign bus.retired_cnt_o = retired_cnt;

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- Pipeline register between the decode stage (id) and the execute stage (ex).
- Captures decoded operands, instruction and write-back control from id and presents them registered to ex.
- Obeys stall/flush commands from ctrl. ex resolves jumps and raises jump_en/hold_flag; ctrl converts these to hold_i/flush_i.
- Contains a flush-window counter (kills FLUSH_CYCLES wrong-path slots) and a retired-slot counter for debug/perf.

Parameters:
- DATA_W, 32, operand/instruction/address width.
- RD_W, 5, destination register address width.
- FLUSH_CYCLES, 1, number of consecutive bubble slots forced after a flush_i pulse (legal range 1..7).
- NOP_INST, 32'h00000013, bubble instruction (addi x0,x0,0).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- inst_i  in  DATA_W  instruction from id.
- inst_addr_i  in  DATA_W  PC of inst_i.
- op1_i  in  DATA_W  operand 1 from id.
- op2_i  in  DATA_W  operand 2 from id.
- reg_wen_i  in  1  register write enable from id.
- rd_addr_i  in  RD_W  destination register from id.
- valid_i  in  1  id slot holds a real instruction.
- hold_i  in  1  ctrl stall: keep current contents.
- flush_i  in  1  ctrl flush (jump taken in ex): kill the slot being loaded and start the flush window.
- inst_o  out  DATA_W  registered instruction to ex.
- inst_addr_o  out  DATA_W  registered PC to ex.
- op1_o  out  DATA_W  registered operand 1 to ex.
- op2_o  out  DATA_W  registered operand 2 to ex.
- reg_wen_o  out  1  registered write enable to ex.
- rd_addr_o  out  RD_W  registered destination to ex.
- valid_o  out  1  registered slot valid.
- flushing_o  out  1  flush window active (flush counter non-zero).
- retired_cnt_o  out  32  count of valid slots handed to ex.

Behaviour:
- Reset: all registered outputs forced to the bubble state at the rising edge where rst=1.
  - inst_o=NOP_INST; inst_addr_o, op1_o, op2_o = 0; reg_wen_o=0; rd_addr_o=0; valid_o=0.
  - Flush counter = 0 (flushing_o=0); retired_cnt_o=0.
  - rst mid-flush or mid-hold cancels both immediately.
- Bubble state is the reset values above. Any bubble has reg_wen_o=0.
- Update priority each edge: rst > flush_i > flush counter != 0 > hold_i > load.
  - flush_i=1: load bubble; counter = FLUSH_CYCLES-1. hold_i is ignored the same cycle.
  - counter != 0 and no flush_i: load bubble; counter decrements by 1. hold_i does not freeze the counter, so the window always completes.
  - hold_i=1 (no flush, counter 0): all outputs keep their values; no counter changes.
  - Otherwise load all inputs. If valid_i=0, load the bubble regardless of data inputs.
- flushing_o = (counter != 0), combinational from the counter register.
- Latency: id inputs appear at the outputs exactly 1 cycle after capture. There is no combinational path from any input to any output.
- retired_cnt_o increments by 1 on every edge where valid_o=1 and hold_i=0 and rst=0, i.e. the slot moves on to ex.
  - 32-bit wrap: 32'hFFFFFFFF -> 0.
  - A flush edge still counts the outgoing valid slot, because ex consumed it (it is the jump).
- flush_i asserted again while counter != 0: counter restarts at FLUSH_CYCLES-1.
- Counter width = 3 bits.

Decomposition:
- defines.v gains:
  - INST_NOP (32'h00000013).
  - ZERO_WORD (32'h0).
  - ZERO_REG (5'b0).
- Sub-module gen_pipe_dff: parameterised width, default value, hold and clear inputs.
  - Instantiated once per output field.
  - Flush counter and retired counter stay in id_ex_pipe.

Test Plan:
1. Reset then plain load: rst 2 cycles; drive inst_i=32'h00500093, inst_addr_i=32'h4, op1_i=0, op2_i=5, reg_wen_i=1, rd_addr_i=1, valid_i=1 -> next cycle outputs equal inputs, valid_o=1; retired_cnt_o=1 one edge later.
2. Hold: load inst 32'h00A00113; assert hold_i 3 cycles while inputs change to 32'hDEADBEEF -> outputs stay 32'h00A00113 for all 3 cycles; retired_cnt_o frozen; after release the new input appears 1 cycle later.
3. Flush with FLUSH_CYCLES=2: valid slot (BNE at 32'h10) at output, pulse flush_i with hold_i=1 -> next 2 cycles inst_o=32'h00000013, reg_wen_o=0, valid_o=0; flushing_o=1 for the first bubble cycle only; retired_cnt_o +1 for the BNE; 3rd cycle loads the input.
4. Invalid input: valid_i=0 with inst_i=32'h00100093, reg_wen_i=1 -> bubble loaded, reg_wen_o=0, retired_cnt_o unchanged.
5. Reset mid-flush: FLUSH_CYCLES=3, flush_i pulse, rst on the next edge -> flushing_o=0 immediately after; with rst low, the following valid input is loaded with no residual bubbles.
6. Counter wrap: force retired count to 32'hFFFFFFFE (backdoor); pass 3 valid slots -> 32'hFFFFFFFF, 0, 1.
